// File: rtl/conv_window_mac.sv
// Sequential MAC engine: one window/filter dot product per handshake, K*K cycles each,
// assembling the stride-1 valid-convolution output map into a flat result register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a window/filter pair
// S_MAC   | one element product accumulated per cycle
// S_STORE | accumulator written into result slot out_idx
// S_DONE  | last slot of the frame stored; done pulses for this cycle
module conv_window_mac #(
    parameter int kernel_size = 2,
    parameter int data_width  = 4,
    parameter int data_height = 4,
    parameter int point_width = 8,
    parameter int acc_width   = 20
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     window_valid,
    output logic                                     window_ready,
    input  logic [point_width*kernel_size*kernel_size-1:0] window,
    input  logic [point_width*kernel_size*kernel_size-1:0] filter,
    output logic [acc_width*(data_width-kernel_size+1)*(data_height-kernel_size+1)-1:0] result,
    output logic                                     busy,
    output logic                                     done
);
    localparam int KK    = kernel_size * kernel_size;
    localparam int OW    = data_width - kernel_size + 1;
    localparam int OH    = data_height - kernel_size + 1;
    localparam int NPTS  = OW * OH;
    localparam int E_W   = $clog2(KK + 1);
    localparam int IDX_W = $clog2(NPTS + 1);
    localparam int VEC_W = point_width * KK;
    localparam int RES_W = acc_width * NPTS;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [E_W-1:0]                e_q, e_d;
    logic [IDX_W-1:0]              out_idx_q, out_idx_d;
    logic signed [acc_width-1:0]   acc_q, acc_d;
    logic [VEC_W-1:0]              win_q, win_d;
    logic [VEC_W-1:0]              filt_q, filt_d;
    logic [RES_W-1:0]              result_q, result_d;
    logic                          window_ready_q, window_ready_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic signed [2*point_width-1:0] prod;

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        out_idx_d = out_idx_q;
        acc_d     = acc_q;
        win_d     = win_q;
        filt_d    = filt_q;
        result_d  = result_q;
        prod      = $signed(win_q[int'(e_q)*point_width +: point_width]) *
                    $signed(filt_q[int'(e_q)*point_width +: point_width]);

        case (state_q)
            S_IDLE: begin
                if (window_valid && window_ready_q) begin
                    win_d   = window;
                    filt_d  = filter;
                    acc_d   = '0;
                    e_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + acc_width'(prod);
                e_d   = e_q + E_W'(1);
                if (e_q == E_W'(KK - 1)) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                result_d[int'(out_idx_q)*acc_width +: acc_width] = acc_q;
                if (out_idx_q == IDX_W'(NPTS - 1)) begin
                    out_idx_d = '0;
                    state_d   = S_DONE;
                end else begin
                    out_idx_d = out_idx_q + IDX_W'(1);
                    state_d   = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered decodes of the next state.
        window_ready_d = (state_d == S_IDLE);
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            e_q            <= '0;
            out_idx_q      <= '0;
            acc_q          <= '0;
            win_q          <= '0;
            filt_q         <= '0;
            result_q       <= '0;
            window_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            e_q            <= e_d;
            out_idx_q      <= out_idx_d;
            acc_q          <= acc_d;
            win_q          <= win_d;
            filt_q         <= filt_d;
            result_q       <= result_d;
            window_ready_q <= window_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign window_ready = window_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
endmodule
